// File: rtl/arp_ctrl_pkg.sv
// Shared types and constants for the ARP sequencer.
`timescale 1ns/1ps
package arp_ctrl_pkg;

    // state     | meaning
    // ST_IDLE   | waiting for a pending reply, request, retry or refresh
    // ST_RPL_TX | ARP reply handed to arp, waiting for tx_done
    // ST_REQ_TX | ARP request handed to arp, waiting for tx_done
    // ST_WAIT_RPL | request sent, retry timer running until a matching reply
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RPL_TX   = 2'd1,
        ST_REQ_TX   = 2'd2,
        ST_WAIT_RPL = 2'd3
    } arp_state_e;

    localparam logic        ARP_OP_REQ = 1'b0;
    localparam logic        ARP_OP_RPL = 1'b1;
    localparam logic [47:0] BCAST_MAC  = 48'hff_ff_ff_ff_ff_ff;

    // Bits needed to hold cycles-1 in a down-counter; never less than one.
    function automatic int tmr_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/arp_ctrl_timer.sv
// Down-counter with synchronous load (clear) and terminal-count flag.
`timescale 1ns/1ps
module arp_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_load,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    // Load on clear, otherwise count down and stick at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_cnt <= '0;
        else if (i_clear)             r_cnt <= i_load;
        else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/arp_ctrl.sv
// ARP sequencer: answers ARP requests, resolves a target IP with retries and
// caches the resolved MAC. Optional macro ARP_AUTO_REFRESH_EN re-resolves the
// cached entry every REFRESH_CYCLES while it is valid.
`timescale 1ns/1ps
module arp_ctrl
    import arp_ctrl_pkg::*;
#(
    parameter int          RETRY_CYCLES   = 125_000_000,
    parameter int          MAX_RETRY      = 3,
    parameter logic [31:0] REFRESH_CYCLES = 32'd1_250_000_000
) (
    input  logic        i_gmii_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_resolve_req,
    input  logic [31:0] i_target_ip,
    output logic        o_busy,
    output logic        o_resolve_done,
    output logic        o_resolve_fail,
    output logic        o_mac_valid,
    output logic [47:0] o_resolved_mac,
    output logic [31:0] o_cached_ip,
    input  logic        i_arp_rx_done,
    input  logic        i_arp_rx_type,
    input  logic [47:0] i_src_mac,
    input  logic [31:0] i_src_ip,
    output logic        o_arp_tx_en,
    output logic        o_arp_tx_type,
    output logic [47:0] o_des_mac,
    output logic [31:0] o_des_ip,
    input  logic        i_tx_done
);
    localparam int          TW         = tmr_width(RETRY_CYCLES);
    localparam logic [TW-1:0] RETRY_LOAD = TW'(RETRY_CYCLES - 1);
    localparam logic [3:0]  MAX_CNT    = 4'(MAX_RETRY);

    arp_state_e  r_state, w_state_nxt;
    logic        r_rpl_pend, w_rpl_pend_nxt;
    logic [47:0] r_rpl_mac, w_rpl_mac_nxt;
    logic [31:0] r_rpl_ip, w_rpl_ip_nxt;
    logic [31:0] r_req_ip, w_req_ip_nxt;
    logic [3:0]  r_retry_cnt, w_retry_cnt_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_lat_vld, w_lat_vld_nxt;
    logic [31:0] r_lat_ip, w_lat_ip_nxt;
    logic        r_retry_flag, w_retry_flag_nxt;
    logic        r_tx_en, w_tx_en_nxt;
    logic        r_tx_type, w_tx_type_nxt;
    logic [47:0] r_des_mac, w_des_mac_nxt;
    logic [31:0] r_des_ip, w_des_ip_nxt;
    logic        r_done, w_done_nxt;
    logic        r_fail, w_fail_nxt;
    logic        r_mac_valid, w_mac_valid_nxt;
    logic [47:0] r_res_mac, w_res_mac_nxt;
    logic [31:0] r_cached_ip, w_cached_ip_nxt;

    logic        w_rx_req, w_rx_match, w_req_ok, w_issue;
    logic [31:0] w_issue_ip;
    logic        w_tmr_clr, w_tmr_en, w_retry_tc;

    assign w_rx_req   = i_arp_rx_done && (i_arp_rx_type == ARP_OP_REQ);
    assign w_rx_match = i_arp_rx_done && (i_arp_rx_type == ARP_OP_RPL) && (i_src_ip == r_req_ip)
                        && ((r_state == ST_REQ_TX) || (r_state == ST_WAIT_RPL));
    assign w_req_ok   = i_resolve_req && !r_busy && !r_lat_vld;
    assign w_tmr_en   = (r_state == ST_WAIT_RPL);

    arp_ctrl_timer #(.W(TW)) u_retry_tmr (
        .i_clk   (i_gmii_clk),
        .i_rst_n (i_sys_rst_n),
        .i_clear (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_load  (RETRY_LOAD),
        .o_tc    (w_retry_tc)
    );

`ifdef ARP_AUTO_REFRESH_EN
    logic r_ref_pend, w_ref_pend_nxt;
    logic r_refreshing, w_refreshing_nxt;
    logic w_ref_clr, w_ref_tc_raw, w_ref_tc;

    // Refresh interval only runs while an idle, valid entry is cached.
    assign w_ref_clr = !r_mac_valid || r_busy || r_ref_pend;
    assign w_ref_tc  = w_ref_tc_raw && !w_ref_clr;

    arp_ctrl_timer #(.W(32)) u_refresh_tmr (
        .i_clk   (i_gmii_clk),
        .i_rst_n (i_sys_rst_n),
        .i_clear (w_ref_clr),
        .i_en    (1'b1),
        .i_load  (REFRESH_CYCLES - 32'd1),
        .o_tc    (w_ref_tc_raw)
    );

    // Refresh bookkeeping registers.
    always_ff @(posedge i_gmii_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_ref_pend   <= 1'b0;
            r_refreshing <= 1'b0;
        end else begin
            r_ref_pend   <= w_ref_pend_nxt;
            r_refreshing <= w_refreshing_nxt;
        end
    end
`else
    logic w_unused_refresh;
    assign w_unused_refresh = ^REFRESH_CYCLES;
`endif

    // Next-state, pulse outputs and cache updates.
    always_comb begin
        w_state_nxt      = r_state;
        w_rpl_pend_nxt   = r_rpl_pend;
        w_rpl_mac_nxt    = r_rpl_mac;
        w_rpl_ip_nxt     = r_rpl_ip;
        w_req_ip_nxt     = r_req_ip;
        w_retry_cnt_nxt  = r_retry_cnt;
        w_busy_nxt       = r_busy;
        w_lat_vld_nxt    = r_lat_vld;
        w_lat_ip_nxt     = r_lat_ip;
        w_retry_flag_nxt = r_retry_flag;
        w_tx_en_nxt      = 1'b0;
        w_tx_type_nxt    = r_tx_type;
        w_des_mac_nxt    = r_des_mac;
        w_des_ip_nxt     = r_des_ip;
        w_done_nxt       = 1'b0;
        w_fail_nxt       = 1'b0;
        w_mac_valid_nxt  = r_mac_valid;
        w_res_mac_nxt    = r_res_mac;
        w_cached_ip_nxt  = r_cached_ip;
        w_tmr_clr        = 1'b0;
        w_issue          = 1'b0;
        w_issue_ip       = r_req_ip;
`ifdef ARP_AUTO_REFRESH_EN
        w_ref_pend_nxt   = r_ref_pend || w_ref_tc;
        w_refreshing_nxt = r_refreshing;
`endif
        // A new request is parked in the latch; an immediate issue below empties it again.
        if (w_req_ok) begin
            w_lat_vld_nxt = 1'b1;
            w_lat_ip_nxt  = i_target_ip;
            if (i_target_ip != r_cached_ip) begin
                w_mac_valid_nxt = 1'b0;
`ifdef ARP_AUTO_REFRESH_EN
                w_ref_pend_nxt  = 1'b0;
`endif
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (r_rpl_pend) begin
                    w_tx_en_nxt    = 1'b1;
                    w_tx_type_nxt  = ARP_OP_RPL;
                    w_des_mac_nxt  = r_rpl_mac;
                    w_des_ip_nxt   = r_rpl_ip;
                    w_rpl_pend_nxt = 1'b0;
                    w_state_nxt    = ST_RPL_TX;
                end else if (r_retry_flag) begin
                    w_issue          = 1'b1;
                    w_retry_flag_nxt = 1'b0;
                end else if (r_lat_vld) begin
                    w_issue         = 1'b1;
                    w_issue_ip      = r_lat_ip;
                    w_lat_vld_nxt   = 1'b0;
                    w_retry_cnt_nxt = 4'd1;
                end else if (w_req_ok && !w_rx_req) begin
                    // A request arriving with an inbound ARP request waits for the reply.
                    w_issue         = 1'b1;
                    w_issue_ip      = i_target_ip;
                    w_lat_vld_nxt   = 1'b0;
                    w_retry_cnt_nxt = 4'd1;
                end
`ifdef ARP_AUTO_REFRESH_EN
                else if (r_ref_pend) begin
                    w_issue          = 1'b1;
                    w_issue_ip       = r_cached_ip;
                    w_ref_pend_nxt   = 1'b0;
                    w_refreshing_nxt = 1'b1;
                    w_retry_cnt_nxt  = 4'd1;
                end
`endif
            end
            ST_RPL_TX: if (i_tx_done) w_state_nxt = ST_IDLE;
            ST_REQ_TX: begin
                if (i_tx_done) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = ST_WAIT_RPL;
                end
            end
            ST_WAIT_RPL: begin
                if (w_retry_tc) begin
                    w_state_nxt = ST_IDLE;
                    if (r_retry_cnt == MAX_CNT) begin
                        w_fail_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
`ifdef ARP_AUTO_REFRESH_EN
                        if (r_refreshing) w_mac_valid_nxt = 1'b0;
                        w_refreshing_nxt = 1'b0;
`endif
                    end else begin
                        w_retry_cnt_nxt  = r_retry_cnt + 4'd1;
                        w_retry_flag_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_issue) begin
            w_req_ip_nxt  = w_issue_ip;
            w_busy_nxt    = 1'b1;
            w_tx_en_nxt   = 1'b1;
            w_tx_type_nxt = ARP_OP_REQ;
            w_des_mac_nxt = BCAST_MAC;
            w_des_ip_nxt  = w_issue_ip;
            w_state_nxt   = ST_REQ_TX;
        end
        // A matching reply wins over tx_done and timeout in the same cycle.
        if (w_rx_match) begin
            w_res_mac_nxt    = i_src_mac;
            w_cached_ip_nxt  = r_req_ip;
            w_mac_valid_nxt  = 1'b1;
            w_done_nxt       = 1'b1;
            w_fail_nxt       = 1'b0;
            w_busy_nxt       = 1'b0;
            w_retry_flag_nxt = 1'b0;
            w_state_nxt      = ST_IDLE;
`ifdef ARP_AUTO_REFRESH_EN
            w_refreshing_nxt = 1'b0;
`endif
        end
        // Inbound requests are captured in every state; the newest one wins.
        if (w_rx_req) begin
            w_rpl_pend_nxt = 1'b1;
            w_rpl_mac_nxt  = i_src_mac;
            w_rpl_ip_nxt   = i_src_ip;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_gmii_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_rpl_pend   <= 1'b0;
            r_rpl_mac    <= '0;
            r_rpl_ip     <= '0;
            r_req_ip     <= '0;
            r_retry_cnt  <= '0;
            r_busy       <= 1'b0;
            r_lat_vld    <= 1'b0;
            r_lat_ip     <= '0;
            r_retry_flag <= 1'b0;
            r_tx_en      <= 1'b0;
            r_tx_type    <= 1'b0;
            r_des_mac    <= BCAST_MAC;
            r_des_ip     <= '0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_mac_valid  <= 1'b0;
            r_res_mac    <= '0;
            r_cached_ip  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rpl_pend   <= w_rpl_pend_nxt;
            r_rpl_mac    <= w_rpl_mac_nxt;
            r_rpl_ip     <= w_rpl_ip_nxt;
            r_req_ip     <= w_req_ip_nxt;
            r_retry_cnt  <= w_retry_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_lat_vld    <= w_lat_vld_nxt;
            r_lat_ip     <= w_lat_ip_nxt;
            r_retry_flag <= w_retry_flag_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_tx_type    <= w_tx_type_nxt;
            r_des_mac    <= w_des_mac_nxt;
            r_des_ip     <= w_des_ip_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
            r_mac_valid  <= w_mac_valid_nxt;
            r_res_mac    <= w_res_mac_nxt;
            r_cached_ip  <= w_cached_ip_nxt;
        end
    end

    assign o_busy         = r_busy;
    assign o_resolve_done = r_done;
    assign o_resolve_fail = r_fail;
    assign o_mac_valid    = r_mac_valid;
    assign o_resolved_mac = r_res_mac;
    assign o_cached_ip    = r_cached_ip;
    assign o_arp_tx_en    = r_tx_en;
    assign o_arp_tx_type  = r_tx_type;
    assign o_des_mac      = r_des_mac;
    assign o_des_ip       = r_des_ip;
endmodule

// File: tb/tb_arp_ctrl.sv
// Bench for arp_ctrl with a loopback arp model and a transmit scoreboard.
`timescale 1ns/1ps
module tb_arp_ctrl;
    import arp_ctrl_pkg::*;

    localparam int          RETRY   = 100;
    localparam int          MAXR    = 3;
    localparam logic [31:0] REFRESH = 32'd500;
    localparam int          TXLAT   = 5;
    localparam logic [31:0] PEER_IP = 32'hC0A8_0166;   // 192.168.1.102
    localparam logic [31:0] IP_50   = 32'hC0A8_0132;   // 192.168.1.50
    localparam logic [31:0] IP_77   = 32'hC0A8_014D;   // 192.168.1.77
    localparam logic [31:0] IP_103  = 32'hC0A8_0167;   // 192.168.1.103
    localparam logic [31:0] IP_FAR  = 32'h0A00_0009;   // 10.0.0.9
    localparam logic [47:0] MAC_A   = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_B   = 48'h0200_0000_0001;
    localparam logic [47:0] MAC_C   = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] MAC_X   = 48'hAABB_CCDD_EEFF;

    logic clk = 1'b0, rst_n = 1'b0;
    logic resolve_req = 1'b0;
    logic [31:0] target_ip = '0;
    logic busy, resolve_done, resolve_fail, mac_valid;
    logic [47:0] resolved_mac, des_mac;
    logic [31:0] cached_ip, des_ip;
    logic arp_tx_en, arp_tx_type;
    logic tx_done = 1'b0;

    logic t_rx_done = 1'b0, t_rx_type = 1'b0;
    logic [47:0] t_src_mac = '0;
    logic [31:0] t_src_ip = '0;
    logic m_rx_done = 1'b0;
    logic [47:0] m_src_mac = '0;
    logic [31:0] m_src_ip = '0;
    logic rx_done, rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    assign rx_done = t_rx_done | m_rx_done;
    assign rx_type = m_rx_done ? ARP_OP_RPL : t_rx_type;
    assign src_mac = m_rx_done ? m_src_mac : t_src_mac;
    assign src_ip  = m_rx_done ? m_src_ip  : t_src_ip;

    logic peer_en = 1'b0;
    logic [31:0] peer_ask_ip = '0, peer_src_ip = '0;
    logic [47:0] peer_mac = '0;

    arp_ctrl #(.RETRY_CYCLES(RETRY), .MAX_RETRY(MAXR), .REFRESH_CYCLES(REFRESH)) dut (
        .i_gmii_clk(clk), .i_sys_rst_n(rst_n), .i_resolve_req(resolve_req), .i_target_ip(target_ip),
        .o_busy(busy), .o_resolve_done(resolve_done), .o_resolve_fail(resolve_fail),
        .o_mac_valid(mac_valid), .o_resolved_mac(resolved_mac), .o_cached_ip(cached_ip),
        .i_arp_rx_done(rx_done), .i_arp_rx_type(rx_type), .i_src_mac(src_mac), .i_src_ip(src_ip),
        .o_arp_tx_en(arp_tx_en), .o_arp_tx_type(arp_tx_type), .o_des_mac(des_mac), .o_des_ip(des_ip),
        .i_tx_done(tx_done)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int n_done = 0, n_fail = 0, last_done_cyc = 0;
    int tx_cyc[$];
    int txdone_cyc[$];

    typedef struct packed {
        logic        ty;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transmit start is matched against the oldest expectation.
    always @(negedge clk) begin
        if (resolve_done) begin n_done++; last_done_cyc = cyc; end
        if (resolve_fail) n_fail++;
        if (arp_tx_en) begin
            tx_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tx: got type %0d ip %0h, nothing expected", arp_tx_type, des_ip);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tx_type", 64'(arp_tx_type), 64'(e.ty));
                check("tx_des_mac", 64'(des_mac), 64'(e.mac));
                check("tx_des_ip", 64'(des_ip), 64'(e.ip));
            end
        end
    end

    // Loopback arp: completes every transmit, and the peer answers requests for peer_ask_ip.
    initial begin
        forever begin
            @(negedge clk);
            if (arp_tx_en && rst_n) begin
                logic ty;
                logic [31:0] ip;
                ty = arp_tx_type;
                ip = des_ip;
                repeat (TXLAT) @(posedge clk);
                #1 tx_done = 1'b1;
                txdone_cyc.push_back(cyc);
                @(posedge clk);
                #1 tx_done = 1'b0;
                if (ty == ARP_OP_REQ && peer_en && ip == peer_ask_ip) begin
                    repeat (3) @(posedge clk);
                    #1 m_rx_done = 1'b1; m_src_ip = peer_src_ip; m_src_mac = peer_mac;
                    @(posedge clk);
                    #1 m_rx_done = 1'b0;
                end
            end
        end
    end

    task automatic pulse_req(input logic [31:0] ip, output int at_cyc);
        @(posedge clk);
        #1 resolve_req = 1'b1; target_ip = ip; at_cyc = cyc;
        @(posedge clk);
        #1 resolve_req = 1'b0;
    endtask

    task automatic inbound_req(input logic [31:0] ip, input logic [47:0] mac);
        @(posedge clk);
        #1 t_rx_done = 1'b1; t_rx_type = ARP_OP_REQ; t_src_ip = ip; t_src_mac = mac;
        @(posedge clk);
        #1 t_rx_done = 1'b0;
    endtask

    task automatic push_exp(input logic ty, input logic [47:0] mac, input logic [31:0] ip, input int n);
        exp_t e;
        e.ty = ty; e.mac = mac; e.ip = ip;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic wait_result(input int d0, input int f0, input int budget, input string name);
        int t;
        t = 0;
        while (n_done == d0 && n_fail == f0 && t < budget) begin @(posedge clk); t++; end
        check(name, 64'(t < budget), 64'd1);
    endtask

    typedef struct {
        logic        inbound;
        logic [31:0] ip;
        logic [47:0] mac;
        logic        peer;
        logic [31:0] peer_src;
        int          exp_tx;
        int          exp_done;
        int          exp_fail;
        logic        exp_valid;
        logic [47:0] exp_mac;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   rq, tx0, td0, d0, f0, t;

        vecs[0] = '{1'b0, PEER_IP, MAC_A, 1'b1, PEER_IP, 1, 1, 0, 1'b1, MAC_A};
        vecs[1] = '{1'b1, IP_50,   MAC_B, 1'b0, 32'd0,   1, 0, 0, 1'b1, MAC_A};
        vecs[2] = '{1'b0, PEER_IP, MAC_X, 1'b1, IP_103,  3, 0, 1, 1'b1, MAC_A};
        vecs[3] = '{1'b0, IP_FAR,  MAC_X, 1'b0, 32'd0,   3, 0, 1, 1'b0, MAC_A};
        vecs[4] = '{1'b1, IP_77,   MAC_C, 1'b0, 32'd0,   1, 0, 0, 1'b0, MAC_A};
        vecs[5] = '{1'b0, IP_77,   MAC_C, 1'b1, IP_77,   1, 1, 0, 1'b1, MAC_C};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_mac_valid", 64'(mac_valid), 0);
        check("rst_tx_en", 64'(arp_tx_en), 0);
        check("rst_des_mac", 64'(des_mac), 64'(BCAST_MAC));
        check("rst_des_ip", 64'(des_ip), 0);
        check("rst_resolved_mac", 64'(resolved_mac), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            tx0 = tx_cyc.size(); td0 = txdone_cyc.size(); d0 = n_done; f0 = n_fail;
            peer_en = vecs[v].peer; peer_ask_ip = vecs[v].ip;
            peer_src_ip = vecs[v].peer_src; peer_mac = vecs[v].mac;
            if (vecs[v].inbound) begin
                push_exp(ARP_OP_RPL, vecs[v].mac, vecs[v].ip, 1);
                inbound_req(vecs[v].ip, vecs[v].mac);
                t = 0;
                while (txdone_cyc.size() == td0 && t < 100) begin @(posedge clk); t++; end
                check($sformatf("v%0d_reply_bound", v), 64'(t < 100), 1);
            end else begin
                push_exp(ARP_OP_REQ, BCAST_MAC, vecs[v].ip, vecs[v].exp_tx);
                pulse_req(vecs[v].ip, rq);
                wait_result(d0, f0, 1500, $sformatf("v%0d_result_bound", v));
            end
            repeat (10) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_tx_count", v), 64'(tx_cyc.size() - tx0), 64'(vecs[v].exp_tx));
            check($sformatf("v%0d_done_count", v), 64'(n_done - d0), 64'(vecs[v].exp_done));
            check($sformatf("v%0d_fail_count", v), 64'(n_fail - f0), 64'(vecs[v].exp_fail));
            check($sformatf("v%0d_mac_valid", v), 64'(mac_valid), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d_resolved_mac", v), 64'(resolved_mac), 64'(vecs[v].exp_mac));
            check($sformatf("v%0d_busy", v), 64'(busy), 0);
            check($sformatf("v%0d_sb_empty", v), 64'(sb.size()), 0);
            if (!vecs[v].inbound && tx_cyc.size() > tx0)
                check($sformatf("v%0d_latency", v), 64'(tx_cyc[tx0] - rq), 1);
            if (vecs[v].exp_done == 1)
                check($sformatf("v%0d_cached_ip", v), 64'(cached_ip), 64'(vecs[v].ip));
            // Retry spacing: tx_done, RETRY cycles waiting, one IDLE cycle, then the pulse.
            if (vecs[v].exp_fail == 1 && tx_cyc.size() >= tx0 + 3 && txdone_cyc.size() >= td0 + 2)
                for (int k = 0; k < 2; k++)
                    check($sformatf("v%0d_retry_gap%0d", v, k),
                          64'(tx_cyc[tx0 + k + 1] - txdone_cyc[td0 + k]), 64'(RETRY + 2));
        end

        // Inbound request and resolve_req in the same cycle: reply first.
        tx0 = tx_cyc.size(); td0 = txdone_cyc.size(); d0 = n_done; f0 = n_fail;
        peer_en = 1'b1; peer_ask_ip = PEER_IP; peer_src_ip = PEER_IP; peer_mac = MAC_A;
        push_exp(ARP_OP_RPL, MAC_B, IP_50, 1);
        push_exp(ARP_OP_REQ, BCAST_MAC, PEER_IP, 1);
        @(posedge clk);
        #1 t_rx_done = 1'b1; t_rx_type = ARP_OP_REQ; t_src_ip = IP_50; t_src_mac = MAC_B;
        resolve_req = 1'b1; target_ip = PEER_IP;
        @(posedge clk);
        #1 t_rx_done = 1'b0; resolve_req = 1'b0;
        wait_result(d0, f0, 500, "sim_result_bound");
        repeat (5) @(negedge clk);
        check("sim_tx_count", 64'(tx_cyc.size() - tx0), 2);
        if (tx_cyc.size() >= tx0 + 2 && txdone_cyc.size() > td0)
            check("sim_req_after_rpl_done", 64'(tx_cyc[tx0 + 1] > txdone_cyc[td0]), 1);
        check("sim_done", 64'(n_done - d0), 1);
        check("sim_mac", 64'(resolved_mac), 64'(MAC_A));
        check("sim_sb_empty", 64'(sb.size()), 0);

`ifdef ARP_AUTO_REFRESH_EN
        // Refresh fires REFRESH cycles after resolve_done while mac_valid holds.
        tx0 = tx_cyc.size();
        push_exp(ARP_OP_REQ, BCAST_MAC, PEER_IP, 1);
        t = 0;
        while (tx_cyc.size() == tx0 && t < 700) begin @(posedge clk); t++; end
        check("ref_bound", 64'(t < 700), 1);
        @(negedge clk);
        check("ref_mac_valid", 64'(mac_valid), 1);
        if (tx_cyc.size() > tx0)
            check("ref_gap", 64'((tx_cyc[tx0] - last_done_cyc) inside {[499:502]}), 1);
        d0 = n_done; f0 = n_fail;
        wait_result(d0, f0, 500, "ref_result_bound");
        repeat (3) @(negedge clk);
        check("ref_valid_after", 64'(mac_valid), 1);
`endif

        // Reset while waiting for a reply.
        peer_en = 1'b0;
        tx0 = tx_cyc.size(); td0 = txdone_cyc.size(); d0 = n_done; f0 = n_fail;
        push_exp(ARP_OP_REQ, BCAST_MAC, IP_FAR, 3);
        pulse_req(IP_FAR, rq);
        t = 0;
        while (txdone_cyc.size() == td0 && t < 100) begin @(posedge clk); t++; end
        check("rstmid_bound", 64'(t < 100), 1);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("rstmid_busy", 64'(busy), 0);
        check("rstmid_mac_valid", 64'(mac_valid), 0);
        check("rstmid_des_mac", 64'(des_mac), 64'(BCAST_MAC));
        check("rstmid_des_ip", 64'(des_ip), 0);
        check("rstmid_cached_ip", 64'(cached_ip), 0);
        check("rstmid_outs", 64'({arp_tx_en, arp_tx_type, resolve_done, resolve_fail}), 0);
        repeat (3) @(posedge clk);
        sb.delete();
        tx0 = tx_cyc.size();
        #1 rst_n = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("rstmid_no_tx", 64'(tx_cyc.size() - tx0), 0);
        check("rstmid_no_result", 64'((n_done - d0) + (n_fail - f0)), 0);
        check("rstmid_busy_after", 64'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
Sequencer for the `arp` block in the GMII domain.
- Answers every received ARP request with an ARP reply to the requester.
- Resolves a user-supplied target IP by sending ARP requests, with timeout and retry.
- Caches the resolved MAC and exposes it to the UDP/IP transmit path.
- Sits between user logic and `arp`, and is the sole driver of arp_tx_en, arp_tx_type, des_mac and des_ip.

Parameters:
- RETRY_CYCLES, default 125_000_000: gmii_clk cycles to wait for a reply before re-requesting (1 s at 125 MHz).
- MAX_RETRY, default 3: request attempts before failing; legal range 1..15.
- REFRESH_CYCLES, default 32'd1_250_000_000: cache refresh interval; used only with ARP_AUTO_REFRESH_EN.

Ports:
- gmii_clk  in  1  clock, 125 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- resolve_req  in  1  one-cycle pulse: resolve target_ip
- target_ip  in  32  IP to resolve; sampled on resolve_req
- busy  out  1  request transaction in progress
- resolve_done  out  1  one-cycle pulse: MAC resolved
- resolve_fail  out  1  one-cycle pulse: retries exhausted
- mac_valid  out  1  resolved_mac is valid
- resolved_mac  out  48  cached MAC for cached_ip
- cached_ip  out  32  IP of the cache entry
- arp_rx_done  in  1  ARP frame received (pulse)
- arp_rx_type  in  1  0 = request, 1 = reply
- src_mac  in  48  sender MAC of the received frame
- src_ip  in  32  sender IP of the received frame
- arp_tx_en  out  1  one-cycle start pulse to `arp`
- arp_tx_type  out  1  0 = request, 1 = reply
- des_mac  out  48  target MAC for the transmission
- des_ip  out  32  target IP for the transmission
- tx_done  in  1  `arp` transmit complete (pulse)

Behaviour:
- Reset values: all outputs 0. des_mac resets to 48'hff_ff_ff_ff_ff_ff. The cache and pending-reply flag are cleared. Asserting reset mid-frame aborts immediately; `arp` is reset by the same signal.
- Reply capture: arp_rx_done && !arp_rx_type sets rpl_pend and latches rpl_mac = src_mac and rpl_ip = src_ip in any state. A second request before service overwrites the latch, so the latest request wins.
- Reply match: arp_rx_done && arp_rx_type && src_ip == req_ip in states REQ_TX or WAIT_RPL:
  - Next cycle: resolved_mac = src_mac, cached_ip = req_ip, mac_valid = 1, resolve_done pulses.
  - Go to IDLE and clear busy.
  - A non-matching reply is ignored.
- FSM states: IDLE, RPL_TX, REQ_TX, WAIT_RPL.
- IDLE:
  - If rpl_pend: drive arp_tx_en = 1, arp_tx_type = 1, des_mac = rpl_mac, des_ip = rpl_ip for exactly one cycle; clear rpl_pend; go to RPL_TX.
  - Else if resolve_req (or a pending latched request): latch req_ip = target_ip, set retry_cnt = 1, set busy = 1, pulse arp_tx_en with arp_tx_type = 0, des_mac = all-ones, des_ip = req_ip; go to REQ_TX.
  - If resolve_req and rpl_pend coincide, the reply goes first. resolve_req is held in a 1-deep latch and the request is issued after the reply completes.
- RPL_TX: wait for tx_done, then go to IDLE.
- REQ_TX: wait for tx_done, clear the timer, go to WAIT_RPL.
- WAIT_RPL:
  - Timer increments each cycle.
  - At timer == RETRY_CYCLES-1:
    - If retry_cnt == MAX_RETRY: pulse resolve_fail, clear busy, go to IDLE. mac_valid and cached entry are unchanged.
    - Else: increment retry_cnt; go to IDLE and re-issue (a pending reply is served first, then the request resumes via an internal retry flag).
- resolve_req while busy, or while the 1-deep latch is full, is ignored.
- des_mac and des_ip hold their last value between pulses.
- Latency: resolve_req in IDLE produces arp_tx_en on the next cycle.
- A new resolve_req with a different IP clears mac_valid at acceptance.

Optional Feature:
Macro: ARP_AUTO_REFRESH_EN
- Defined: while mac_valid, a 32-bit counter counts to REFRESH_CYCLES-1, then issues an internal resolve of cached_ip through the normal request path. mac_valid stays 1 during refresh. On failure, mac_valid clears and resolve_fail pulses.
- Undefined: no refresh counter; the cache persists until reset or a new resolve_req.

Decomposition:
- Package arp_ctrl_pkg:
  - FSM state enum.
  - ARP_OP_REQ = 1'b0, ARP_OP_RPL = 1'b1.
  - BCAST_MAC = 48'hff_ff_ff_ff_ff_ff.
  - Timer width derived from RETRY_CYCLES via $clog2.
- Sub-module arp_ctrl_timer: clear / enable / terminal-count counter, instanced for the retry timer and, under the macro, the refresh timer.

Test Plan:
Bench uses RETRY_CYCLES = 100, MAX_RETRY = 3, and a loopback `arp` with BOARD_IP = 192.168.1.102.
- Successful resolve: resolve_req with target_ip = 192.168.1.102, peer reply src_mac = 00-11-22-33-44-55 → one arp_tx_en with type 0 and des_mac all-ones; then resolve_done pulses once, mac_valid = 1, resolved_mac = 48'h001122334455.
- Timeout: resolve_req with no reply → exactly 3 request pulses spaced by tx_done + 100 cycles; then resolve_fail pulses once, mac_valid = 0, busy = 0.
- Reply service: inject a request from 192.168.1.50 / 02-00-00-00-00-01 → one arp_tx_en with type 1, des_ip = 192.168.1.50, des_mac = 48'h020000000001; rpl_pend clears after tx_done.
- Simultaneous events: received request and resolve_req in the same cycle → reply pulse first; request pulse only after the reply's tx_done.
- Reset mid-operation: deassert sys_rst_n during WAIT_RPL → all outputs 0, des_mac all-ones, mac_valid = 0; no pulse after reset releases.
- Refresh (ARP_AUTO_REFRESH_EN, REFRESH_CYCLES = 500): after a successful resolve → automatic request to cached_ip 500 cycles later while mac_valid stays 1.
